// File: rtl/uart_pkg.sv
// Shared FSM state type and clamp limits for the UART sample timer.
// Build option: UART_TRIPLE_SAMPLE_EN selects three-point sampling in uart_sample_decode.
package uart_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam int MIN_PRESCALE   = 4;
   localparam int MIN_FRAME_BITS = 1;
endpackage

// File: rtl/uart_sample_decode.sv
// Decodes the position within a bit into sample strobes around the bit midpoint.
// Build option: UART_TRIPLE_SAMPLE_EN strobes at mid-1, mid, mid+1; otherwise only at mid.
module uart_sample_decode
   import uart_pkg::*;
#(
   parameter int PWIDTH = 6
) (
   input  logic [PWIDTH-1:0] i_edge_cnt,
   input  logic [PWIDTH-1:0] i_prescale_q,
   input  logic              i_run,
   output logic              o_sample_stb,
   output logic [1:0]        o_sample_idx
);

   logic [PWIDTH-1:0] w_mid;
   assign w_mid = i_prescale_q >> 1;

`ifdef UART_TRIPLE_SAMPLE_EN
   localparam logic [PWIDTH-1:0] P_ONE = PWIDTH'(1);
   logic [PWIDTH-1:0] w_mid_lo;
   logic [PWIDTH-1:0] w_mid_hi;
   assign w_mid_lo = w_mid - P_ONE;
   assign w_mid_hi = w_mid + P_ONE;

   always_comb begin
      o_sample_stb = 1'b0;
      o_sample_idx = 2'd0;
      if (i_run) begin
         if (i_edge_cnt == w_mid_lo) begin
            o_sample_stb = 1'b1;
            o_sample_idx = 2'd0;
         end else if (i_edge_cnt == w_mid) begin
            o_sample_stb = 1'b1;
            o_sample_idx = 2'd1;
         end else if (i_edge_cnt == w_mid_hi) begin
            o_sample_stb = 1'b1;
            o_sample_idx = 2'd2;
         end
      end
   end
`else
   assign o_sample_stb = i_run && (i_edge_cnt == w_mid);
   assign o_sample_idx = 2'd0;
`endif

endmodule

// File: rtl/uart_sample_timer.sv
// UART receive timing: counts clocks within a bit and bits within a frame, emits sample strobes.
// Build option: UART_TRIPLE_SAMPLE_EN (passed through to uart_sample_decode).
module uart_sample_timer
   import uart_pkg::*;
#(
   parameter int PWIDTH = 6,
   parameter int BWIDTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [PWIDTH-1:0] prescale,
   input  logic [BWIDTH-1:0] frame_bits,
   output logic [PWIDTH-1:0] edge_counter,
   output logic [BWIDTH-1:0] bit_counter,
   output logic              sample_stb,
   output logic [1:0]        sample_idx,
   output logic              bit_done,
   output logic              frame_done,
   output logic              busy
);

   localparam logic [PWIDTH-1:0] P_PONE = PWIDTH'(1);
   localparam logic [BWIDTH-1:0] P_BONE = BWIDTH'(1);
   localparam logic [PWIDTH-1:0] P_PMIN = PWIDTH'(MIN_PRESCALE);
   localparam logic [BWIDTH-1:0] P_BMIN = BWIDTH'(MIN_FRAME_BITS);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [PWIDTH-1:0] r_prescale_q, w_prescale_nxt;
   logic [BWIDTH-1:0] r_frame_bits_q, w_frame_bits_nxt;
   logic [PWIDTH-1:0] r_edge_cnt, w_edge_nxt;
   logic [BWIDTH-1:0] r_bit_cnt, w_bit_nxt;
   logic              w_run;
   logic              w_bit_done;
   logic              w_frame_done;

   assign w_run        = (r_state == RUN);
   assign w_bit_done   = w_run && (r_edge_cnt == r_prescale_q - P_PONE);
   assign w_frame_done = w_bit_done && (r_bit_cnt == r_frame_bits_q - P_BONE);

   always_comb begin
      w_state_nxt      = r_state;
      w_prescale_nxt   = r_prescale_q;
      w_frame_bits_nxt = r_frame_bits_q;
      w_edge_nxt       = r_edge_cnt;
      w_bit_nxt        = r_bit_cnt;
      case (r_state)
         IDLE: begin
            if (enable) begin
               w_state_nxt      = RUN;
               w_prescale_nxt   = (prescale < P_PMIN) ? P_PMIN : prescale;
               w_frame_bits_nxt = (frame_bits < P_BMIN) ? P_BMIN : frame_bits;
               w_edge_nxt       = '0;
               w_bit_nxt        = '0;
            end
         end
         RUN: begin
            // Abort takes priority over frame completion.
            if (!enable) begin
               w_state_nxt = IDLE;
               w_edge_nxt  = '0;
               w_bit_nxt   = '0;
            end else if (w_frame_done) begin
               w_state_nxt = DONE;
               w_edge_nxt  = '0;
               w_bit_nxt   = '0;
            end else if (w_bit_done) begin
               w_edge_nxt = '0;
               w_bit_nxt  = r_bit_cnt + P_BONE;
            end else begin
               w_edge_nxt = r_edge_cnt + P_PONE;
            end
         end
         DONE: begin
            if (!enable) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state        <= IDLE;
         r_prescale_q   <= P_PMIN;
         r_frame_bits_q <= P_BMIN;
         r_edge_cnt     <= '0;
         r_bit_cnt      <= '0;
      end else begin
         r_state        <= w_state_nxt;
         r_prescale_q   <= w_prescale_nxt;
         r_frame_bits_q <= w_frame_bits_nxt;
         r_edge_cnt     <= w_edge_nxt;
         r_bit_cnt      <= w_bit_nxt;
      end
   end

   uart_sample_decode #(.PWIDTH(PWIDTH)) u_decode (
      .i_edge_cnt   (r_edge_cnt),
      .i_prescale_q (r_prescale_q),
      .i_run        (w_run),
      .o_sample_stb (sample_stb),
      .o_sample_idx (sample_idx)
   );

   assign edge_counter = r_edge_cnt;
   assign bit_counter  = r_bit_cnt;
   assign bit_done     = w_bit_done;
   assign frame_done   = w_frame_done;
   assign busy         = w_run;

endmodule

// File: tb/tb_uart_sample_timer.sv
// Directed bench for uart_sample_timer: frame timing, clamping, sampling, abort and reset.
module tb_uart_sample_timer;
   localparam int PW = 6;
   localparam int BW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic [PW-1:0] prescale;
   logic [BW-1:0] frame_bits;
   logic [PW-1:0] edge_counter;
   logic [BW-1:0] bit_counter;
   logic          sample_stb;
   logic [1:0]    sample_idx;
   logic          bit_done;
   logic          frame_done;
   logic          busy;

   int n_checks = 0;
   int n_errors = 0;
   int n_bd, bad, fd_cyc, mask, sig;

`ifdef UART_TRIPLE_SAMPLE_EN
   localparam int MASK8 = 56;   // edges 3,4,5
   localparam int SIG8  = 2304; // idx 0,1,2 at edges 3,4,5
   localparam int MASK4 = 14;   // edges 1,2,3
   localparam int SIG4  = 144;
`else
   localparam int MASK8 = 16;   // edge 4
   localparam int SIG8  = 0;
   localparam int MASK4 = 4;    // edge 2
   localparam int SIG4  = 0;
`endif

   uart_sample_timer #(.PWIDTH(PW), .BWIDTH(BW)) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .prescale     (prescale),
      .frame_bits   (frame_bits),
      .edge_counter (edge_counter),
      .bit_counter  (bit_counter),
      .sample_stb   (sample_stb),
      .sample_idx   (sample_idx),
      .bit_done     (bit_done),
      .frame_done   (frame_done),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Observes a frame from its first RUN cycle (c=1); stops at frame_done or after max cycles.
   task automatic run_frame(input int per, input int max, input int chg_at, input int chg_val,
                            output int o_bd, output int o_bad, output int o_fd,
                            output int o_mask, output int o_sig);
      o_bd = 0; o_bad = 0; o_fd = 0; o_mask = 0; o_sig = 0;
      for (int c = 1; c <= max; c++) begin
         if (c == chg_at) prescale = PW'(chg_val);
         if (bit_done) o_bd++;
         if (bit_done != ((c % per) == 0)) o_bad++;
         if (sample_stb && bit_counter == 0) begin
            o_mask |= 1 << edge_counter;
            o_sig  |= int'(sample_idx) << (2 * edge_counter);
         end
         if (frame_done) begin
            o_fd = c;
            break;
         end
         if (c < max) tick();
      end
   endtask

   initial begin
      rst = 1'b0; enable = 1'b0; prescale = 8; frame_bits = 10;
      tick(); tick();
      chk("rst_edge", edge_counter, 0);
      chk("rst_bit", bit_counter, 0);
      chk("rst_busy", busy, 0);
      chk("rst_stb", sample_stb, 0);
      chk("rst_bd", bit_done, 0);
      chk("rst_fd", frame_done, 0);
      rst = 1'b1;
      tick();
      chk("idle_busy", busy, 0);

      // Frame A: prescale 8, 10 bits; prescale changed to 16 at bit 3 must be ignored
      enable = 1'b1;
      tick();
      chk("a_busy", busy, 1);
      chk("a_edge0", edge_counter, 0);
      chk("a_bit0", bit_counter, 0);
      run_frame(8, 90, 25, 16, n_bd, bad, fd_cyc, mask, sig);
      chk("a_nbd", n_bd, 10);
      chk("a_period", bad, 0);
      chk("a_fdcyc", fd_cyc, 80);
      chk("a_fdbit", bit_counter, 9);
      chk("a_mask", mask, MASK8);
      chk("a_sig", sig, SIG8);
      tick();
      chk("a_done_busy", busy, 0);
      chk("a_done_edge", edge_counter, 0);
      chk("a_done_bit", bit_counter, 0);
      chk("a_done_stb", sample_stb, 0);
      repeat (3) tick();
      chk("a_noretrig", busy, 0);
      chk("a_noretrig_bd", bit_done, 0);
      enable = 1'b0;
      tick();
      chk("a_idle", busy, 0);

      // Frame B picks up prescale 16
      enable = 1'b1;
      tick();
      chk("b_busy", busy, 1);
      run_frame(16, 200, 0, 0, n_bd, bad, fd_cyc, mask, sig);
      chk("b_period", bad, 0);
      chk("b_fdcyc", fd_cyc, 160);
      tick();
      enable = 1'b0;
      tick();

      // Frame C: prescale 2 clamps to 4
      prescale = 2; frame_bits = 3; enable = 1'b1;
      tick();
      run_frame(4, 20, 0, 0, n_bd, bad, fd_cyc, mask, sig);
      chk("c_nbd", n_bd, 3);
      chk("c_period", bad, 0);
      chk("c_fdcyc", fd_cyc, 12);
      chk("c_mask", mask, MASK4);
      chk("c_sig", sig, SIG4);
      tick();
      enable = 1'b0;
      tick();

      // Frame D: frame_bits 0 clamps to 1
      prescale = 5; frame_bits = 0; enable = 1'b1;
      tick();
      run_frame(5, 20, 0, 0, n_bd, bad, fd_cyc, mask, sig);
      chk("d_nbd", n_bd, 1);
      chk("d_fdcyc", fd_cyc, 5);
      tick();
      enable = 1'b0;
      tick();

      // Abort at bit 5, edge 2
      prescale = 8; frame_bits = 10; enable = 1'b1;
      tick();
      run_frame(8, 43, 0, 0, n_bd, bad, fd_cyc, mask, sig);
      chk("ab_nofd", fd_cyc, 0);
      chk("ab_bit", bit_counter, 5);
      chk("ab_edge", edge_counter, 2);
      enable = 1'b0;
      chk("ab_fd_now", frame_done, 0);
      tick();
      chk("ab_busy", busy, 0);
      chk("ab_edge0", edge_counter, 0);
      chk("ab_bit0", bit_counter, 0);
      chk("ab_fd", frame_done, 0);

      // Reset asserted at bit 4, then restart
      enable = 1'b1;
      tick();
      run_frame(8, 33, 0, 0, n_bd, bad, fd_cyc, mask, sig);
      chk("mr_bit", bit_counter, 4);
      rst = 1'b0;
      tick();
      chk("mr_busy", busy, 0);
      chk("mr_edge", edge_counter, 0);
      chk("mr_bit0", bit_counter, 0);
      chk("mr_stb", sample_stb, 0);
      chk("mr_idx", sample_idx, 0);
      chk("mr_bd", bit_done, 0);
      chk("mr_fd", frame_done, 0);
      rst = 1'b1;
      tick();
      chk("mr_restart_busy", busy, 1);
      chk("mr_restart_bit", bit_counter, 0);
      chk("mr_restart_edge", edge_counter, 0);
      run_frame(8, 90, 0, 0, n_bd, bad, fd_cyc, mask, sig);
      chk("mr_period", bad, 0);
      chk("mr_fdcyc", fd_cyc, 80);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_sample_timer.md
UART_SAMPLE_TIMER -- requirements
Module: uart_sample_timer

Interface
REQ-001 SHALL have parameter PWIDTH, default 6, width of prescale and edge_counter.
REQ-002 SHALL have parameter BWIDTH, default 4, width of frame_bits and bit_counter.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  frame request; low aborts.
REQ-006 SHALL have port prescale  input  PWIDTH  oversampling ratio (clocks per bit).
REQ-007 SHALL have port frame_bits  input  BWIDTH  bits per frame including start/stop.
REQ-008 SHALL have port edge_counter  output  PWIDTH  clock index within current bit.
REQ-009 SHALL have port bit_counter  output  BWIDTH  bit index within current frame.
REQ-010 SHALL have port sample_stb  output  1  sample-point strobe.
REQ-011 SHALL have port sample_idx  output  2  index of current strobe (0..2).
REQ-012 SHALL have port bit_done  output  1  last clock of a bit.
REQ-013 SHALL have port frame_done  output  1  last clock of a frame.
REQ-014 SHALL have port busy  output  1  high in RUN state.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 IDLE with enable=1 SHALL go to RUN next cycle, latching prescale_q and frame_bits_q; edge_counter=0, bit_counter=0 in first RUN cycle.
REQ-017 Latched values SHALL hold for the whole frame; input changes mid-frame SHALL have no effect.
REQ-018 prescale below 4 SHALL be latched as 4; frame_bits of 0 SHALL be latched as 1.
REQ-019 In RUN edge_counter SHALL increment each cycle, wrapping to 0 after prescale_q-1.
REQ-020 bit_done SHALL be high, combinationally, exactly when RUN and edge_counter==prescale_q-1.
REQ-021 bit_counter SHALL increment in the cycle following bit_done, never wrapping within a frame.
REQ-022 frame_done SHALL be high when bit_done and bit_counter==frame_bits_q-1; next state DONE, counters cleared to 0.
REQ-023 DONE SHALL hold, all strobes low, until enable=0, then go to IDLE; no retrigger while enable stays high.
REQ-024 enable=0 in RUN SHALL abort: next cycle IDLE, counters 0; strobes in the abort cycle still reflect current counter.
REQ-025 Midpoint SHALL be mid = prescale_q >> 1 (floor).
REQ-026 sample_stb and sample_idx SHALL be combinational from registered state, low/0 outside RUN.
REQ-027 busy SHALL equal (state==RUN).

Reset
REQ-028 rst=0 at a rising edge SHALL force IDLE, edge_counter=0, bit_counter=0, prescale_q=4, frame_bits_q=1, overriding enable.
REQ-029 Consequently all outputs SHALL be 0 in the cycle after reset, including reset asserted mid-frame.

Configuration
REQ-030 Macro UART_TRIPLE_SAMPLE_EN defined: sample_stb high at edge_counter==mid-1, mid, mid+1 with sample_idx 0, 1, 2.
REQ-031 Macro undefined: sample_stb high only at edge_counter==mid, sample_idx tied 0.

Structure
REQ-032 Package uart_pkg SHALL hold FSM state typedef and constants MIN_PRESCALE=4, MIN_FRAME_BITS=1.
REQ-033 Sub-module uart_sample_decode SHALL decode (edge_counter, prescale_q, run) into sample_stb/sample_idx; macro applies there.

Verification
REQ-034 prescale=8, frame_bits=10, enable held -> bit_done every 8 cycles, frame_done at cycle 80 after RUN entry, then DONE, busy=0.
REQ-035 prescale=8, triple on -> sample_stb at edge_counter 3,4,5 with idx 0,1,2; triple off -> only at 4.
REQ-036 prescale=2 -> behaves as 4: bit_done every 4 cycles, samples at 1,2,3 (triple).
REQ-037 change prescale 8->16 at bit 3 -> bit period stays 8 to frame end; next frame uses 16.
REQ-038 enable dropped at bit 5, edge 2 -> next cycle IDLE, counters 0, no frame_done.
REQ-039 rst=0 at bit 4 -> next cycle all outputs 0; enable=1 re-starts frame from bit 0.
